// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding is kept as plain constants so legacy tools can consume it.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 6;
    localparam int unsigned STATS_W    = 16;
    localparam int unsigned CNT_W      = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_FLUSH    = 2'd1;
    localparam state_t ST_STALL    = 2'd2;
    localparam state_t ST_MEM_WAIT = 2'd3;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the ID and EX stages.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mread,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = id_uses_rs && (id_rs == ex_rd);
        rt_hit   = id_uses_rt && (id_rt == ex_rd);
        // Register 0 is hardwired, so a load into it never creates a hazard.
        load_use = ex_mread && (ex_rd != '0) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: branch flush, data-memory wait and load-use stall.
// Optional statistics counters are enabled with PIPE_CTRL_STATS_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned LU_STALL     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               ex_mread,
    input  logic [REG_AW-1:0]  ex_rd,
    input  logic               br_taken,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic               ifid_we,
    output logic               idex_we,
    output logic               ifid_flush,
    output logic               idex_bubble,
`ifdef PIPE_CTRL_STATS_EN
    output logic [STATS_W-1:0] stall_cycles,
    output logic [STATS_W-1:0] flush_events,
    output logic [STATS_W-1:0] mem_wait_cycles,
`endif
    output logic               busy
);

    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LU_STALL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             run_eval;
    logic             br_accept;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_mread   (ex_mread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_eval    = 1'b0;
        br_accept   = 1'b0;

        case (state_q)
            ST_RUN: run_eval = 1'b1;
            ST_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                cnt_d       = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = ST_RUN;
            end
            ST_STALL: begin
                if (br_taken) begin
                    run_eval = 1'b1;
                end else begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // EX is frozen, so a held branch is only acted on once memory completes.
                if (mem_ready) begin
                    run_eval = 1'b1;
                end else begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    idex_we = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (run_eval) begin
            if (br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                br_accept   = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_INIT;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end else if (mem_req && !mem_ready) begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                idex_we = 1'b0;
                state_d = ST_MEM_WAIT;
            end else if (load_use) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                if (LU_STALL > 1) begin
                    state_d = ST_STALL;
                    cnt_d   = STALL_INIT;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end else begin
                state_d = ST_RUN;
            end
        end

        // Reset loads NOPs into both buffers while holding the PC.
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            br_accept   = 1'b0;
        end

        busy = (state_q != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles    <= '0;
            flush_events    <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (!pc_we) stall_cycles <= sat_inc(stall_cycles);
            if (br_accept) flush_events <= sat_inc(flush_events);
            if (state_q == ST_MEM_WAIT) mem_wait_cycles <= sat_inc(mem_wait_cycles);
        end
    end
`endif

endmodule
